// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl -- multi-cycle control unit for the 16-bit CPU core.
//
// Fetches one instruction per pass (FETCH -> DECODE -> EXEC -> WB), decodes
// it and drives every ALU / PC / register-file control line. HALT parks the
// core until reset.
//
// Optional feature macro: CTRL_STEP_EN
//   defined   : single-step mode. key_ok is synchronised (2 flops) and
//               edge-detected; each rising edge seen while the FSM waits in
//               FETCH releases exactly one instruction fetch.
//   undefined : free-running; key_ok is ignored and no synchroniser is built.
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   key_ok         single-step key (level, asynchronous; CTRL_STEP_EN only)
//   imem_req       instruction fetch request (registered)
//   imem_ack       fetch acknowledge, imem_data valid in the same cycle
//   imem_data      instruction word
//   alu_zero_flag  ALU zero result, sampled on the EXEC cycle only
//   alu_sel        ALU operation select (opcode)
//   rf_raddr1/2    operand register addresses (IR[7:4], IR[3:0])
//   rf_waddr       write-back register (IR[11:8])
//   rf_we          register-file write enable, one-cycle pulse in WB
//   pc_inc         PC += 1, one-cycle pulse in WB
//   pc_load        PC load / branch strobe, one-cycle pulse in WB
//   pc_offset      branch offset (IR[3:0])
//   pc_target      jump target (IR[7:0])
//   halted         core stopped on HALT
//   retired        retired-instruction count (wraps)
//   state_dbg      current FSM state, for debug and checkers
//
// Fetch handshake: a fetch completes in the cycle where imem_req and
// imem_ack are both high at the rising clock edge; imem_data is captured on
// that edge and imem_req is low from the next cycle on. imem_ack seen while
// imem_req is low is ignored. The memory may hold off imem_ack for any
// number of cycles; imem_req stays high until it arrives.
// ---------------------------------------------------------------------------
module cpu_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int OP_SIZE     = 4,
    parameter int MEM_SIZE    = 8,
    parameter int OFFSET_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   key_ok,
    output logic                   imem_req,
    input  logic                   imem_ack,
    input  logic [WORD_SIZE-1:0]   imem_data,
    input  logic                   alu_zero_flag,
    output logic [OP_SIZE-1:0]     alu_sel,
    output logic [3:0]             rf_raddr1,
    output logic [3:0]             rf_raddr2,
    output logic [3:0]             rf_waddr,
    output logic                   rf_we,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic [OFFSET_SIZE-1:0] pc_offset,
    output logic [MEM_SIZE-1:0]    pc_target,
    output logic                   halted,
    output logic [15:0]            retired,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [OP_SIZE-1:0] OP_BEQ  = OP_SIZE'(12);
    localparam logic [OP_SIZE-1:0] OP_JMP  = OP_SIZE'(13);
    localparam logic [OP_SIZE-1:0] OP_NOP  = OP_SIZE'(14);
    localparam logic [OP_SIZE-1:0] OP_HALT = OP_SIZE'(15);

    state_t               state;
    state_t               state_next;
    logic [WORD_SIZE-1:0] ir;
    logic                 req_q;
    logic                 req_next;
    logic                 taken_q;
    logic [15:0]          retired_q;

    logic [OP_SIZE-1:0]   opcode;
    logic                 is_alu;
    logic                 fetch_go;
    logic                 wb_load;
    logic                 wb_inc;
    logic                 wb_we;
    logic                 retire_now;

    assign opcode   = ir[WORD_SIZE-1 -: OP_SIZE];
    // Opcodes 0x0..0xB are ALU operations; everything from BEQ up is control.
    assign is_alu   = (opcode < OP_BEQ);
    assign fetch_go = (state == S_FETCH) && req_q && imem_ack;

    // -----------------------------------------------------------------------
    // Single-step key conditioning
    // -----------------------------------------------------------------------
`ifdef CTRL_STEP_EN
    logic key_meta;
    logic key_sync;
    logic key_prev;
    logic step_edge;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_meta <= key_ok;
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end

    // One-cycle pulse per press, no matter how long the key is held.
    assign step_edge = key_sync & ~key_prev;
`else
    logic unused_key;
    assign unused_key = key_ok;
`endif

    // -----------------------------------------------------------------------
    // State register and instruction-side registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_FETCH;
            req_q     <= 1'b0;
            ir        <= '0;
            taken_q   <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state <= state_next;
            req_q <= req_next;
            if (fetch_go) begin
                ir <= imem_data;
            end
            // The zero flag only matters for BEQ, and only on the EXEC cycle.
            if (state == S_EXEC) begin
                taken_q <= (opcode == OP_BEQ) && alu_zero_flag;
            end
            if (retire_now) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and request logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_next   = 1'b0;
        retire_now = 1'b0;

        case (state)
            S_FETCH: begin
                if (fetch_go) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                    // HALT counts as retired the moment the core stops.
                    retire_now = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                state_next = S_FETCH;
                retire_now = 1'b1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // imem_req is registered so it stays low during reset and rises on
        // the first edge after reset release.
`ifdef CTRL_STEP_EN
        // Wait in FETCH with the request low until a key edge arrives; the
        // request then holds until acknowledged. Edges at any other time
        // (including the acknowledge cycle) are dropped.
        if (state == S_FETCH && !fetch_go) begin
            req_next = req_q | step_edge;
        end
`else
        req_next = (state_next == S_FETCH);
`endif
    end

    // -----------------------------------------------------------------------
    // Write-back strobes: decoded from the state so that an asynchronous
    // reset removes them in the same instant.
    // -----------------------------------------------------------------------
    always_comb begin
        wb_we   = 1'b0;
        wb_inc  = 1'b0;
        wb_load = 1'b0;
        if (state == S_WB) begin
            if (is_alu) begin
                wb_we  = 1'b1;
                wb_inc = 1'b1;
            end else if (opcode == OP_BEQ) begin
                wb_load = taken_q;
                wb_inc  = ~taken_q;
            end else if (opcode == OP_JMP) begin
                wb_load = 1'b1;
            end else if (opcode == OP_NOP) begin
                wb_inc = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Decoded fields come straight from IR, so they are stable from
    // DECODE until the next fetch completes, and zero out of reset.
    // -----------------------------------------------------------------------
    assign imem_req  = req_q;
    assign alu_sel   = opcode;
    assign rf_raddr1 = ir[7:4];
    assign rf_raddr2 = ir[3:0];
    assign rf_waddr  = ir[11:8];
    assign pc_offset = ir[OFFSET_SIZE-1:0];
    assign pc_target = ir[MEM_SIZE-1:0];
    assign rf_we     = wb_we;
    assign pc_inc    = wb_inc;
    assign pc_load   = wb_load;
    assign halted    = (state == S_HALT);
    assign retired   = retired_q;
    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Structural properties of the control outputs
    // -----------------------------------------------------------------------
    a_pc_exclusive : assert property (@(posedge clk) disable iff (!rstn)
        !(pc_inc && pc_load));

    a_strobe_in_wb : assert property (@(posedge clk) disable iff (!rstn)
        (rf_we || pc_inc || pc_load) |-> (state == S_WB));

    a_no_req_when_halted : assert property (@(posedge clk) disable iff (!rstn)
        halted |-> !imem_req);

endmodule

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl -- self-checking bench for cpu_ctrl.
//
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Fixed vectors come from a table of {instruction, wait, flag, expected
// strobes}; random instructions are checked against a small opcode-rule
// model. Hand-written sequences cover reset, reset during EXEC, JMP + HALT
// and (with CTRL_STEP_EN) the single-step key.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_ctrl;

    logic        clk;
    logic        rstn;
    logic        key_ok;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        alu_zero_flag;
    logic [3:0]  alu_sel;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [3:0]  rf_waddr;
    logic        rf_we;
    logic        pc_inc;
    logic        pc_load;
    logic [3:0]  pc_offset;
    logic [7:0]  pc_target;
    logic        halted;
    logic [15:0] retired;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_retired = 0;

    cpu_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_ok        (key_ok),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .alu_zero_flag (alu_zero_flag),
        .alu_sel       (alu_sel),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_waddr      (rf_waddr),
        .rf_we         (rf_we),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .pc_offset     (pc_offset),
        .pc_target     (pc_target),
        .halted        (halted),
        .retired       (retired),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (state %0d)", name, act, exp, state_dbg);
        end
    endtask

    // Expected write-back strobes from the opcode rules alone.
    function automatic void model_wb(input logic [3:0] op, input bit zero,
                                     output bit we, output bit inc, output bit load);
        we   = (op <= 4'hB);
        load = (op == 4'hD) || (op == 4'hC && zero);
        inc  = (op <= 4'hB) || (op == 4'hC && !zero) || (op == 4'hE);
    endfunction

    // Wait (bounded) until the DUT requests a fetch; in step mode press the key.
    task automatic wait_req(input string tag, output bit ok);
        int n;
        n = 0;
`ifdef CTRL_STEP_EN
        key_ok = 1'b1;
`endif
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        key_ok = 1'b0;
        ok = (imem_req === 1'b1);
        check({tag, "/req_rise"}, 64'(imem_req), 64'(1));
    endtask

    // Run one instruction through the DUT, checking every phase. For HALT it
    // returns in the DECODE cycle after the field checks.
    task automatic do_instr(input logic [15:0] instr, input int wait_n, input bit zero,
                            input bit e_we, input bit e_inc, input bit e_load,
                            input string tag);
        bit ok;
        int req_cycles;
        int span;
        wait_req(tag, ok);
        if (!ok) return;
        req_cycles = 0;
        span = 0;
        for (int i = 0; i < wait_n; i++) begin
            imem_ack = 1'b0;
            imem_data = 16'($urandom);
            alu_zero_flag = 1'($urandom_range(0, 1));
            if (imem_req) req_cycles++;
            tick();
            span++;
        end
        imem_ack = 1'b1;
        imem_data = instr;
        alu_zero_flag = ~zero;
        if (imem_req) req_cycles++;
        tick();
        span++;
        // DECODE: ack is now ignored, the zero flag is noise.
        imem_ack = 1'($urandom_range(0, 1));
        imem_data = 16'($urandom);
        check({tag, "/req_drop"}, 64'(imem_req), 64'(0));
        check({tag, "/req_cycles"}, 64'(req_cycles), 64'(wait_n + 1));
        check({tag, "/fields"},
              64'({alu_sel, rf_raddr1, rf_raddr2, rf_waddr, pc_offset, pc_target}),
              64'({instr[15:12], instr[7:4], instr[3:0], instr[11:8], instr[3:0], instr[7:0]}));
        if (instr[15:12] == 4'hF) return;
        check({tag, "/decode_strobes"}, 64'({rf_we, pc_inc, pc_load}), 64'(0));
        tick();
        span++;
        // EXEC: the only cycle where the zero flag counts.
        alu_zero_flag = zero;
        check({tag, "/exec_strobes"}, 64'({rf_we, pc_inc, pc_load}), 64'(0));
        tick();
        span++;
        // WB
        alu_zero_flag = ~zero;
        check({tag, "/wb_strobes"}, 64'({rf_we, pc_inc, pc_load}), 64'({e_we, e_inc, e_load}));
        // WB is the (4 + wait)-th cycle counted from the first request cycle.
        check({tag, "/wb_cycle"}, 64'(span + 1), 64'(wait_n + 4));
        exp_retired++;
        tick();
        imem_ack = 1'b0;
        check({tag, "/post_strobes"}, 64'({rf_we, pc_inc, pc_load}), 64'(0));
        check({tag, "/retired"}, 64'(retired), 64'(exp_retired[15:0]));
        check({tag, "/alu_sel_hold"}, 64'(alu_sel), 64'(instr[15:12]));
    endtask

    // Called with rstn already low: everything must be zero, then release.
    task automatic reset_tail(input string tag);
        #1;
        check({tag, "/outs_in_reset"},
              64'({imem_req, rf_we, pc_inc, pc_load, halted, alu_sel, rf_raddr1,
                   rf_raddr2, rf_waddr, pc_offset, pc_target}), 64'(0));
        check({tag, "/retired_in_reset"}, 64'(retired), 64'(0));
        for (int i = 0; i < 2; i++) begin
            tick();
            check({tag, "/held_reset"}, 64'({imem_req, rf_we, pc_inc, pc_load}), 64'(0));
        end
        rstn = 1'b1;
        #1;
        check({tag, "/req_before_edge"}, 64'(imem_req), 64'(0));
        @(posedge clk);
        #1;
`ifndef CTRL_STEP_EN
        check({tag, "/req_after_edge"}, 64'(imem_req), 64'(1));
`else
        check({tag, "/step_no_req"}, 64'(imem_req), 64'(0));
`endif
        exp_retired = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] instr;
        int          wait_n;
        bit          zero;
        bit          we;
        bit          inc;
        bit          load;
        string       tag;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        bit m_we, m_inc, m_load;
        logic [3:0] op;
        logic [31:0] r;
        int w;
        bit z;
        int fetches;
        int req_seen;

        vecs[0] = '{16'h3123, 0, 1'b0, 1'b1, 1'b1, 1'b0, "alu_3123"};
        vecs[1] = '{16'hC005, 0, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken"};
        vecs[2] = '{16'hC005, 0, 1'b0, 1'b0, 1'b1, 1'b0, "beq_not_taken"};
        vecs[3] = '{16'hD0A7, 1, 1'b0, 1'b0, 1'b0, 1'b1, "jmp_a7"};
        vecs[4] = '{16'hE000, 2, 1'b1, 1'b0, 1'b1, 1'b0, "nop"};
        vecs[5] = '{16'h0FFF, 5, 1'b0, 1'b1, 1'b1, 1'b0, "alu_stall5"};
        vecs[6] = '{16'hB456, 0, 1'b1, 1'b1, 1'b1, 1'b0, "alu_b_flag"};
        vecs[7] = '{16'hCFFA, 3, 1'b1, 1'b0, 1'b0, 1'b1, "beq_stall3"};

        // ---------------- reset ----------------
        rstn = 1'b0;
        key_ok = 1'b0;
        imem_ack = 1'b0;
        imem_data = 16'h0;
        alu_zero_flag = 1'b0;
        tick();
        reset_tail("reset");

`ifdef CTRL_STEP_EN
        // No key edge: no fetch, even with ack offered.
        req_seen = 0;
        for (int i = 0; i < 30; i++) begin
            imem_ack = 1'b1;
            imem_data = 16'h3123;
            if (imem_req) req_seen++;
            tick();
        end
        imem_ack = 1'b0;
        check("step/no_key_no_req", 64'(req_seen), 64'(0));
        check("step/no_key_retired", 64'(retired), 64'(0));
        // One long press: exactly one instruction.
        key_ok = 1'b1;
        fetches = 0;
        for (int i = 0; i < 50; i++) begin
            imem_ack = imem_req;
            imem_data = 16'hE000;
            if (imem_req) fetches++;
            tick();
        end
        key_ok = 1'b0;
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("step/hold50_fetches", 64'(fetches), 64'(1));
        exp_retired++;
        check("step/hold50_retired", 64'(retired), 64'(exp_retired));
`endif

        // ---------------- table ----------------
        for (int i = 0; i < 8; i++) begin
            do_instr(vecs[i].instr, vecs[i].wait_n, vecs[i].zero,
                     vecs[i].we, vecs[i].inc, vecs[i].load, vecs[i].tag);
        end

        // ---------------- random ----------------
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 14));
            r = $urandom;
            w = $urandom_range(0, 3);
            z = 1'($urandom_range(0, 1));
            model_wb(op, z, m_we, m_inc, m_load);
            do_instr({op, r[11:0]}, w, z, m_we, m_inc, m_load, "rand");
        end

        // ---------------- reset during EXEC ----------------
        wait_req("rst_exec", ok);
        if (ok) begin
            imem_ack = 1'b1;
            imem_data = 16'h3123;
            tick();
            imem_ack = 1'b0;
            tick();
            // now in EXEC; assert reset asynchronously mid-cycle
            #2;
            rstn = 1'b0;
            #1;
            check("rst_exec/no_we", 64'({rf_we, pc_inc, pc_load}), 64'(0));
            reset_tail("rst_exec");
        end

        // ---------------- JMP then HALT ----------------
        do_instr(16'hD0A7, 0, 1'b0, 1'b0, 1'b0, 1'b1, "jmp_then_halt");
        check("jmp_then_halt/target", 64'(pc_target), 64'(8'hA7));
        do_instr(16'hF000, 0, 1'b0, 1'b0, 1'b0, 1'b0, "halt");
        imem_ack = 1'b0;
        tick();
        exp_retired++;
        check("halt/halted", 64'(halted), 64'(1));
        check("halt/retired", 64'(retired), 64'(2));
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            key_ok = (i % 8) < 4;
            imem_ack = 1'b1;
            alu_zero_flag = 1'($urandom_range(0, 1));
            tick();
            check("halt/quiet",
                  64'({imem_req, rf_we, pc_inc, pc_load, halted}), 64'(5'b00001));
        end
        key_ok = 1'b0;
        imem_ack = 1'b0;
        check("halt/retired_stays", 64'(retired), 64'(exp_retired));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
